// File: rtl/hazard3_sdspi_blkbuf_pkg.sv
// +-----------------------------------------------------------------------------+
// | hazard3_sdspi_blkbuf_pkg                                                    |
// | Register map, field positions and engine encodings for hazard3_sdspi_blkbuf |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package hazard3_sdspi_blkbuf_pkg;

  localparam logic [15:0] OFF_CMD    = 16'h0000;
  localparam logic [15:0] OFF_SECTOR = 16'h0004;
  localparam logic [15:0] OFF_STATUS = 16'h0008;
  localparam logic [15:0] OFF_IRQ_EN = 16'h000C;

  localparam int CMD_START   = 0;
  localparam int CMD_DIR     = 1;
  localparam int CMD_BUF_LSB = 8;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_ERR       = 2;
  localparam int STAT_CODE_LSB  = 4;
  localparam int STAT_BUF_LSB   = 8;
  localparam int STAT_COUNT_LSB = 16;

  localparam int IRQ_DONE_IE = 0;
  localparam int IRQ_ERR_IE  = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAITNB = 3'd1,
    ST_RD     = 3'd2,
    ST_WR     = 3'd3,
    ST_FINISH = 3'd4
  } eng_state_t;

  typedef enum logic [1:0] {
    WPH_FETCH   = 2'd0,
    WPH_LOAD    = 2'd1,
    WPH_VALID   = 2'd2,
    WPH_RELEASE = 2'd3
  } wr_phase_t;

  function automatic int log2_ceil(input int v);
    return $clog2(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard3_sdspi_blkbuf_wordram.sv
// +-----------------------------------------------------------------------------+
// | sdspi_wordram (hazard3_sdspi_blkbuf_wordram)                                |
// | Dual-port 32-bit block RAM, synchronous read on both ports                  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module hazard3_sdspi_blkbuf_wordram #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [31:0]   i_a_wdata,
  output logic [31:0]   o_a_rdata,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [31:0]   i_b_wdata,
  output logic [31:0]   o_b_rdata
);

  logic [31:0] r_mem [WORDS];

  // Callers guarantee the two ports never target the same buffer at once.
  always_ff @(posedge clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
    o_a_rdata <= r_mem[i_a_addr];
    o_b_rdata <= r_mem[i_b_addr];
  end

endmodule

`default_nettype wire

// File: rtl/hazard3_sdspi_blkbuf.sv
// +-----------------------------------------------------------------------------+
// | hazard3_sdspi_blkbuf                                                        |
// | APB multi-buffer SD sector mover; optional IRQ via `define SDSPI_IRQ_EN      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module hazard3_sdspi_blkbuf
  import hazard3_sdspi_blkbuf_pkg::*;
#(
  parameter int          BLOCK_BYTES = 512,
  parameter int          NUM_BUFS    = 2,
  parameter logic [15:0] BUF_BASE    = 16'h1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [15:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_addr,
  input  logic        sd_busy,
  input  logic        sd_error,
  input  logic [2:0]  sd_error_code,
  output logic [7:0]  sd_din,
  output logic        sd_din_valid,
  input  logic        sd_din_taken,
  input  logic [7:0]  sd_dout,
  input  logic        sd_dout_avail,
  output logic        sd_dout_taken,
  output logic        irq
);

  localparam int BB_W      = log2_ceil(BLOCK_BYTES);
  localparam int WPB       = BLOCK_BYTES / 4;
  localparam int WORDS     = NUM_BUFS * WPB;
  localparam int AW        = log2_ceil(WORDS);
  localparam int WIN_BYTES = NUM_BUFS * BLOCK_BYTES;

  eng_state_t  r_state;
  wr_phase_t   r_wph;
  logic        r_dir;
  logic        r_done;
  logic        r_err;
  logic        r_op_err;
  logic        r_rd_pend;
  logic [2:0]  r_err_code;
  logic [1:0]  r_act_buf;
  logic [15:0] r_count;
  logic [31:0] r_sector;
  logic [23:0] r_word;

  logic          w_access, w_busy, w_in_win, w_beyond, w_buf_err, w_cmd_err, w_err;
  logic          w_buf_rd, w_reg_wr, w_start, w_a_we, w_b_we;
  logic [15:0]   w_off, w_pbuf, w_roff;
  logic [AW-1:0] w_a_addr, w_eng_addr;
  logic [31:0]   w_ram_a_rdata, w_ram_b_rdata, w_status, w_irq_en_rd;
  logic [7:0]    w_eng_rbyte;

  assign w_access  = psel & penable;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_in_win  = (paddr >= BUF_BASE);
  assign w_off     = paddr - BUF_BASE;
  assign w_roff    = {paddr[15:2], 2'b00};
  assign w_beyond  = (32'(w_off) >= 32'(WIN_BYTES));
  assign w_pbuf    = w_off >> BB_W;
  assign w_buf_err = w_in_win & (w_beyond | (w_busy & (w_pbuf == 16'(r_act_buf))));
  assign w_cmd_err = ~w_in_win & pwrite & (w_roff == OFF_CMD) & pwdata[CMD_START] &
                     (w_busy | ({30'd0, pwdata[CMD_BUF_LSB +: 2]} >= 32'(NUM_BUFS)));
  assign w_err     = w_cmd_err | w_buf_err;

  assign w_buf_rd  = w_access & w_in_win & ~pwrite & ~w_buf_err;
  assign w_reg_wr  = w_access & pwrite & ~w_in_win & ~w_err;
  assign w_start   = w_reg_wr & (w_roff == OFF_CMD) & pwdata[CMD_START];
  assign w_a_we    = w_access & pwrite & w_in_win & ~w_buf_err;
  assign w_a_addr  = w_off[AW+1:2];

  // Buffer reads take one wait state while the synchronous RAM produces data.
  assign pready  = w_access & (~w_buf_rd | r_rd_pend);
  assign pslverr = w_access & w_err;

  assign w_eng_addr  = AW'(int'(r_act_buf) * WPB + int'(r_count[BB_W-1:2]));
  assign w_eng_rbyte = w_ram_b_rdata[{r_count[1:0], 3'b000} +: 8];
  assign w_b_we      = (r_state == ST_RD) & ~sd_dout_taken & sd_dout_avail &
                       (r_count[1:0] == 2'd3) & ~sd_error;

  hazard3_sdspi_blkbuf_wordram #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .i_a_we    (w_a_we),
    .i_a_addr  (w_a_addr),
    .i_a_wdata (pwdata),
    .o_a_rdata (w_ram_a_rdata),
    .i_b_we    (w_b_we),
    .i_b_addr  (w_eng_addr),
    .i_b_wdata ({sd_dout, r_word}),
    .o_b_rdata (w_ram_b_rdata)
  );

  always_comb begin
    w_status = '0;
    w_status[STAT_BUSY]                = w_busy;
    w_status[STAT_DONE]                = r_done;
    w_status[STAT_ERR]                 = r_err;
    w_status[STAT_CODE_LSB +: 3]       = r_err_code;
    w_status[STAT_BUF_LSB +: 2]        = r_act_buf;
    w_status[STAT_COUNT_LSB +: 16]     = r_count;
  end

`ifdef SDSPI_IRQ_EN
  logic [1:0] r_irq_en;
  always_ff @(posedge clk) begin
    if (reset)                                 r_irq_en <= '0;
    else if (w_reg_wr && w_roff == OFF_IRQ_EN) r_irq_en <= pwdata[1:0];
  end
  assign irq         = (r_done & r_irq_en[IRQ_DONE_IE]) | (r_err & r_irq_en[IRQ_ERR_IE]);
  assign w_irq_en_rd = {30'd0, r_irq_en};
`else
  assign irq         = 1'b0;
  assign w_irq_en_rd = '0;
`endif

  always_comb begin
    prdata = '0;
    if (w_access && !pwrite && !w_err) begin
      if (w_in_win) begin
        if (r_rd_pend) prdata = w_ram_a_rdata;
      end else begin
        case (w_roff)
          OFF_SECTOR: prdata = r_sector;
          OFF_STATUS: prdata = w_status;
          OFF_IRQ_EN: prdata = w_irq_en_rd;
          default:    prdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_wph         <= WPH_FETCH;
      r_dir         <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_op_err      <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_err_code    <= '0;
      r_act_buf     <= '0;
      r_count       <= '0;
      r_sector      <= '0;
      r_word        <= '0;
      sd_rd         <= 1'b0;
      sd_wr         <= 1'b0;
      sd_addr       <= '0;
      sd_din        <= '0;
      sd_din_valid  <= 1'b0;
      sd_dout_taken <= 1'b0;
    end else begin
      r_rd_pend <= w_buf_rd & ~r_rd_pend;
      if (w_reg_wr && w_roff == OFF_SECTOR) r_sector <= pwdata;
      if (w_reg_wr && w_roff == OFF_STATUS) begin
        if (pwdata[STAT_DONE]) r_done <= 1'b0;
        if (pwdata[STAT_ERR])  r_err  <= 1'b0;
      end

      case (r_state)
        ST_IDLE: if (w_start) begin
          sd_addr   <= r_sector;
          r_dir     <= pwdata[CMD_DIR];
          r_act_buf <= pwdata[CMD_BUF_LSB +: 2];
          r_count   <= '0;
          r_op_err  <= 1'b0;
          r_state   <= ST_WAITNB;
        end
        ST_WAITNB: if (!sd_busy) begin
          if (r_dir) begin
            sd_wr   <= 1'b1;
            r_wph   <= WPH_FETCH;
            r_state <= ST_WR;
          end else begin
            sd_rd   <= 1'b1;
            r_state <= ST_RD;
          end
        end
        ST_RD: begin
          if (!sd_dout_taken) begin
            if (sd_dout_avail) begin
              case (r_count[1:0])
                2'd0:    r_word[7:0]   <= sd_dout;
                2'd1:    r_word[15:8]  <= sd_dout;
                2'd2:    r_word[23:16] <= sd_dout;
                default: ;
              endcase
              sd_dout_taken <= 1'b1;
              r_count       <= r_count + 16'd1;
            end
          end else if (!sd_dout_avail) begin
            sd_dout_taken <= 1'b0;
            if (r_count == 16'(BLOCK_BYTES)) begin
              sd_rd   <= 1'b0;
              r_state <= ST_FINISH;
            end
          end
        end
        ST_WR: begin
          case (r_wph)
            WPH_FETCH: r_wph <= WPH_LOAD;
            WPH_LOAD: begin
              sd_din       <= w_eng_rbyte;
              sd_din_valid <= 1'b1;
              r_wph        <= WPH_VALID;
            end
            WPH_VALID: if (sd_din_taken) begin
              sd_din_valid <= 1'b0;
              r_count      <= r_count + 16'd1;
              r_wph        <= WPH_RELEASE;
            end
            WPH_RELEASE: if (!sd_din_taken) begin
              if (r_count == 16'(BLOCK_BYTES)) begin
                sd_wr   <= 1'b0;
                r_state <= ST_FINISH;
              end else if (r_count[1:0] == 2'd0) begin
                r_wph <= WPH_FETCH;
              end else begin
                r_wph <= WPH_LOAD;
              end
            end
            default: r_wph <= WPH_FETCH;
          endcase
        end
        ST_FINISH: if (!sd_busy) begin
          r_state <= ST_IDLE;
          if (!r_op_err) r_done <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase

      // A controller error overrides whatever the engine was doing.
      if (r_state != ST_IDLE && sd_error) begin
        r_err         <= 1'b1;
        r_err_code    <= sd_error_code;
        r_op_err      <= 1'b1;
        sd_rd         <= 1'b0;
        sd_wr         <= 1'b0;
        sd_din_valid  <= 1'b0;
        sd_dout_taken <= 1'b0;
        r_state       <= ST_FINISH;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard3_sdspi_blkbuf.sv
// +-----------------------------------------------------------------------------+
// | tb_hazard3_sdspi_blkbuf                                                     |
// | Directed bench with a behavioural sd_controller model                       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_hazard3_sdspi_blkbuf;

  localparam int BLOCK = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        sd_rd, sd_wr;
  logic [31:0] sd_addr;
  logic        sd_busy, sd_error;
  logic [2:0]  sd_error_code;
  logic [7:0]  sd_din;
  logic        sd_din_valid, sd_din_taken;
  logic [7:0]  sd_dout;
  logic        sd_dout_avail, sd_dout_taken;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  int         m_err_at   = -1;
  logic [2:0] m_err_code = 3'd0;
  int         m_rd_hs    = 0;
  int         m_wr_hs    = 0;
  logic [7:0] m_wr_bytes[$];

  always #5 clk = ~clk;

  hazard3_sdspi_blkbuf dut (
    .clk           (clk),
    .reset         (reset),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pready        (pready),
    .pslverr       (pslverr),
    .sd_rd         (sd_rd),
    .sd_wr         (sd_wr),
    .sd_addr       (sd_addr),
    .sd_busy       (sd_busy),
    .sd_error      (sd_error),
    .sd_error_code (sd_error_code),
    .sd_din        (sd_din),
    .sd_din_valid  (sd_din_valid),
    .sd_din_taken  (sd_din_taken),
    .sd_dout       (sd_dout),
    .sd_dout_avail (sd_dout_avail),
    .sd_dout_taken (sd_dout_taken),
    .irq           (irq)
  );

  // ---------------- card model ----------------
  task automatic model_read();
    int t;
    sd_busy = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      if (i == m_err_at) begin
        sd_error_code = m_err_code;
        sd_error      = 1'b1;
        @(posedge clk); #1;
        sd_error      = 1'b0;
        break;
      end
      sd_dout       = 8'(i);
      sd_dout_avail = 1'b1;
      t = 0;
      while (sd_dout_taken !== 1'b1 && sd_rd === 1'b1 && t < 50) begin
        @(posedge clk); #1; t++;
      end
      sd_dout_avail = 1'b0;
      if (sd_dout_taken !== 1'b1) break;
      m_rd_hs++;
      t = 0;
      while (sd_dout_taken === 1'b1 && t < 50) begin
        @(posedge clk); #1; t++;
      end
    end
    t = 0;
    while (sd_rd === 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    sd_busy = 1'b0;
  endtask

  task automatic model_write();
    int t;
    sd_busy = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      t = 0;
      while (sd_din_valid !== 1'b1 && sd_wr === 1'b1 && t < 50) begin
        @(posedge clk); #1; t++;
      end
      if (sd_din_valid !== 1'b1) break;
      m_wr_bytes.push_back(sd_din);
      m_wr_hs++;
      sd_din_taken = 1'b1;
      @(posedge clk); #1;
      t = 0;
      while (sd_din_valid === 1'b1 && t < 50) begin
        @(posedge clk); #1; t++;
      end
      sd_din_taken = 1'b0;
      @(posedge clk); #1;
    end
    t = 0;
    while (sd_wr === 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    sd_busy = 1'b0;
  endtask

  initial begin : card_model
    sd_busy = 1'b0; sd_error = 1'b0; sd_error_code = 3'd0;
    sd_dout = 8'd0; sd_dout_avail = 1'b0; sd_din_taken = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sd_rd === 1'b1)      model_read();
      else if (sd_wr === 1'b1) model_write();
    end
  end

  // ---------------- APB master ----------------
  task automatic apb(input logic wr, input logic [15:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output int waits);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1; waits = 0;
    #4;
    while (pready !== 1'b1 && waits < 8) begin
      @(posedge clk); #5; waits++;
    end
    rd  = prdata;
    err = pslverr;
    if (pready !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL apb_timeout addr=%h: pready never rose", a);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wait_idle(output logic [31:0] st);
    logic [31:0] d; logic e; int w; int k;
    st = 32'hFFFF_FFFF;
    for (k = 0; k < 3000; k++) begin
      apb(1'b0, 16'h0008, 32'd0, d, e, w);
      st = d;
      if (d[0] === 1'b0) break;
    end
    n_chk++;
    if (st[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL engine_timeout: status=%h still busy, required idle", st);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [78:0] obs; logic [31:0] d; logic e; int w;
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    obs = {sd_rd, sd_wr, sd_addr, sd_din, sd_din_valid, sd_dout_taken, irq, pready, pslverr, prdata};
    n_chk++;
    if (obs !== 79'd0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", obs); end
    reset = 1'b0;
    apb(1'b0, 16'h0008, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h required 0", d); end
    apb(1'b0, 16'h0004, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_sector: got %h required 0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d; logic e; int w;
    apb(1'b1, 16'h0004, 32'hDEAD_BEEF, d, e, w);
    apb(1'b0, 16'h0004, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sector_rw: got %h required deadbeef", d); end
    apb(1'b0, 16'h0000, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL cmd_reads_zero: got %h required 0", d); end
    apb(1'b0, 16'h0010, 32'd0, d, e, w);
    n_chk++;
    if ({e, d} !== 33'd0) begin n_fail++; $display("FAIL unmapped_read: got err=%b data=%h required 0/0", e, d); end
`ifdef SDSPI_IRQ_EN
    apb(1'b1, 16'h000C, 32'h3, d, e, w);
    apb(1'b0, 16'h000C, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL irq_en_rw: got %h required 3", d); end
    apb(1'b1, 16'h000C, 32'h0, d, e, w);
`else
    apb(1'b1, 16'h000C, 32'h3, d, e, w);
    apb(1'b0, 16'h000C, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL irq_en_absent: got %h required 0", d); end
`endif
    apb(1'b1, 16'h1400, 32'h1234, d, e, w);
    n_chk++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL beyond_write_err: got %b required 1", e); end
    apb(1'b0, 16'h1400, 32'd0, d, e, w);
    n_chk++;
    if ({e, d} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL beyond_read_err: got err=%b data=%h required 1/0", e, d); end
    apb(1'b1, 16'h0000, 32'h0000_0201, d, e, w);
    n_chk++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL bad_buf_index: got %b required 1", e); end
    apb(1'b0, 16'h0008, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL bad_buf_no_start: status %h required 0", d); end
  endtask

  task automatic test_buf_rw();
    logic [31:0] d; logic e; int w;
    apb(1'b1, 16'h1000, 32'h1122_3344, d, e, w);
    n_chk++;
    if ({e, w} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL buf_write_timing: err=%b waits=%0d required 0/0", e, w); end
    apb(1'b0, 16'h1000, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'h1122_3344) begin n_fail++; $display("FAIL buf_readback: got %h required 11223344", d); end
    n_chk++;
    if (w !== 1) begin n_fail++; $display("FAIL buf_read_waits: got %0d required 1", w); end
  endtask

  task automatic test_card_read();
    logic [31:0] d, st; logic e; int w;
    apb(1'b1, 16'h0004, 32'd5, d, e, w);
    apb(1'b1, 16'h0000, 32'h0000_0001, d, e, w);
    wait_idle(st);
    n_chk++;
    if (sd_addr !== 32'd5) begin n_fail++; $display("FAIL rd_sd_addr: got %h required 5", sd_addr); end
    n_chk++;
    if (st !== 32'h0200_0002) begin n_fail++; $display("FAIL rd_status: got %h required 02000002", st); end
    n_chk++;
    if (sd_rd !== 1'b0) begin n_fail++; $display("FAIL rd_sd_rd_low: got %b required 0", sd_rd); end
    n_chk++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL rd_irq_masked: got %b required 0", irq); end
    apb(1'b0, 16'h1004, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'h0706_0504) begin n_fail++; $display("FAIL rd_word1: got %h required 07060504", d); end
    apb(1'b0, 16'h1100, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'h0302_0100) begin n_fail++; $display("FAIL rd_word64: got %h required 03020100", d); end
    apb(1'b0, 16'h11FC, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'hFFFE_FDFC) begin n_fail++; $display("FAIL rd_word127: got %h required fffefdfc", d); end
  endtask

  task automatic test_card_write();
    logic [31:0] d, st; logic e; int w; int bad; logic [7:0] exp;
    for (int k = 0; k < BLOCK / 4; k++) apb(1'b1, 16'(16'h1200 + 4 * k), 32'(k), d, e, w);
    apb(1'b1, 16'h0004, 32'd9, d, e, w);
    apb(1'b1, 16'h0008, 32'h2, d, e, w);
    m_wr_bytes.delete();
    m_wr_hs = 0;
    apb(1'b1, 16'h0000, 32'h0000_0103, d, e, w);
    wait_idle(st);
    n_chk++;
    if (st !== 32'h0200_0102) begin n_fail++; $display("FAIL wr_status: got %h required 02000102", st); end
    n_chk++;
    if (sd_addr !== 32'd9) begin n_fail++; $display("FAIL wr_sd_addr: got %h required 9", sd_addr); end
    n_chk++;
    if (m_wr_hs !== BLOCK) begin n_fail++; $display("FAIL wr_handshakes: got %0d required 512", m_wr_hs); end
    bad = 0;
    for (int i = 0; i < m_wr_bytes.size(); i++) begin
      exp = (i % 4 == 0) ? 8'(i / 4) : 8'd0;
      if (m_wr_bytes[i] !== exp) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL wr_bytes: %0d bytes differ, required 0", bad); end
  endtask

  task automatic test_busy_conflict();
    logic [31:0] d, st; logic e; int w;
    apb(1'b1, 16'h0008, 32'h6, d, e, w);
    apb(1'b1, 16'h0004, 32'd7, d, e, w);
    apb(1'b1, 16'h0000, 32'h0000_0001, d, e, w);
    apb(1'b1, 16'h0000, 32'h0000_0101, d, e, w);
    n_chk++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL busy_start_err: got %b required 1", e); end
    apb(1'b0, 16'h1000, 32'd0, d, e, w);
    n_chk++;
    if ({e, d} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL busy_buf0_read: err=%b data=%h required 1/0", e, d); end
    apb(1'b1, 16'h1008, 32'hBAD0_BAD0, d, e, w);
    n_chk++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL busy_buf0_write: got %b required 1", e); end
    apb(1'b0, 16'h0008, 32'd0, d, e, w);
    n_chk++;
    if ({d[9:8], d[0]} !== 3'b001) begin n_fail++; $display("FAIL busy_state_kept: status %h required busy buf0", d); end
    n_chk++;
    if (sd_addr !== 32'd7) begin n_fail++; $display("FAIL busy_sd_addr: got %h required 7", sd_addr); end
    apb(1'b0, 16'h1208, 32'd0, d, e, w);
    n_chk++;
    if ({e, d} !== {1'b0, 32'd2}) begin n_fail++; $display("FAIL busy_buf1_read: err=%b data=%h required 0/2", e, d); end
    apb(1'b1, 16'h1208, 32'd2, d, e, w);
    n_chk++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL busy_buf1_write: got %b required 0", e); end
    wait_idle(st);
    n_chk++;
    if (st !== 32'h0200_0002) begin n_fail++; $display("FAIL busy_final_status: got %h required 02000002", st); end
    apb(1'b0, 16'h1008, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'h0B0A_0908) begin n_fail++; $display("FAIL busy_word2: got %h required 0b0a0908", d); end
  endtask

  task automatic test_sd_error();
    logic [31:0] d, st; logic e; int w;
    apb(1'b1, 16'h0008, 32'h6, d, e, w);
    m_err_at = 100; m_err_code = 3'd3;
    apb(1'b1, 16'h0000, 32'h0000_0001, d, e, w);
    wait_idle(st);
    m_err_at = -1;
    n_chk++;
    if (st !== 32'h0064_0034) begin n_fail++; $display("FAIL err_status: got %h required 00640034", st); end
    n_chk++;
    if (sd_busy !== 1'b0) begin n_fail++; $display("FAIL err_busy_order: sd_busy=%b required 0 once idle", sd_busy); end
    apb(1'b1, 16'h0008, 32'h4, d, e, w);
    apb(1'b0, 16'h0008, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'h0064_0030) begin n_fail++; $display("FAIL err_w1c: got %h required 00640030", d); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d; logic e; int w; int t; logic [78:0] obs;
    apb(1'b1, 16'h0008, 32'h6, d, e, w);
    m_wr_hs = 0;
    apb(1'b1, 16'h0000, 32'h0000_0103, d, e, w);
    t = 0;
    while (m_wr_hs < 200 && t < 5000) begin @(posedge clk); t++; end
    n_chk++;
    if (m_wr_hs < 200) begin n_fail++; $display("FAIL midop_progress: got %0d bytes required 200", m_wr_hs); end
    #1; reset = 1'b1;
    @(posedge clk); #1;
    obs = {sd_rd, sd_wr, sd_addr, sd_din, sd_din_valid, sd_dout_taken, irq, pready, pslverr, prdata};
    n_chk++;
    if (obs !== 79'd0) begin n_fail++; $display("FAIL midop_outputs: got %h required 0", obs); end
    reset = 1'b0;
    apb(1'b0, 16'h0008, 32'd0, d, e, w);
    n_chk++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL midop_status: got %h required 0", d); end
    repeat (20) @(posedge clk);
  endtask

`ifdef SDSPI_IRQ_EN
  task automatic test_irq();
    logic [31:0] d, st; logic e; int w;
    apb(1'b1, 16'h000C, 32'h1, d, e, w);
    apb(1'b1, 16'h0004, 32'd5, d, e, w);
    apb(1'b1, 16'h0000, 32'h0000_0001, d, e, w);
    wait_idle(st);
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b required 1", irq); end
    apb(1'b1, 16'h0008, 32'h2, d, e, w);
    n_chk++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b required 0", irq); end
  endtask
`endif

  initial begin : main
    test_reset();
    test_regs();
    test_buf_rw();
    test_card_read();
    test_card_write();
    test_busy_conflict();
    test_sd_error();
    test_reset_midop();
`ifdef SDSPI_IRQ_EN
    test_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
